// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the DAC-stepping converter blocks.
//   adc_state_e   - converter FSM states (idle, DAC settle, comparator decide)
//   ADC_MODE_*    - conversion mode encodings as seen on the mode input
//   ch_width()    - mux-select width for a given channel count, never below 1
package adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDecide
  } adc_state_e;

  localparam logic ADC_MODE_RAMP = 1'b0;
  localparam logic ADC_MODE_SAR  = 1'b1;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/r2r_adc_conv_if.sv
// r2r_adc_conv_if: bundle between the converter, the board-level R2R/comparator/mux and the
// sample consumers.
//   enable, mode, comp_result          - control and comparator inputs to the converter
//   dac_code, ch_sel                   - R2R drive and analog mux select
//   data_valid, data_out, data_ch      - result strobe, value and channel tag
//   busy                               - converter FSM is not idle
// master: the converter side. slave: the surrounding board/consumer side.
interface r2r_adc_conv_if
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 1
) ();

  localparam int unsigned CH_W = ch_width(NUM_CH);

  logic             enable;
  logic             mode;
  logic             comp_result;
  logic [WIDTH-1:0] dac_code;
  logic [CH_W-1:0]  ch_sel;
  logic             data_valid;
  logic [WIDTH-1:0] data_out;
  logic [CH_W-1:0]  data_ch;
  logic             busy;

  modport master (
    input  enable,
    input  mode,
    input  comp_result,
    output dac_code,
    output ch_sel,
    output data_valid,
    output data_out,
    output data_ch,
    output busy
  );

  modport slave (
    output enable,
    output mode,
    output comp_result,
    input  dac_code,
    input  ch_sel,
    input  data_valid,
    input  data_out,
    input  data_ch,
    input  busy
  );

endinterface

// File: rtl/adc_settle_timer.sv
// adc_settle_timer: down-counter timing the DAC settle interval of one conversion step.
//   clk, reset - clock, synchronous active-high reset
//   i_load     - restart the interval (counter loaded with SETTLE_CYCLES - 1)
//   o_done     - counter has reached zero; the interval is over this cycle
// Loading on the edge that enters the settle state makes that state last exactly
// SETTLE_CYCLES cycles.
module adc_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_done
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LoadVal;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/r2r_adc_conv.sv
// r2r_adc_conv: R2R DAC + external comparator converter, ramp or SAR, multiplexed channels.
//   clk, reset - clock, synchronous active-high reset
//   io_bus     - r2r_adc_conv_if.master: enable/mode/comp_result in; dac_code, ch_sel,
//                data_valid, data_out, data_ch, busy out
// Result in both modes is the largest code at which the comparator still reports 1
// (0 if none). Each step is SETTLE_CYCLES cycles of settle followed by one decide cycle.
module r2r_adc_conv
  import adc_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 10000,
  parameter int unsigned NUM_CH        = 1
) (
  input logic         clk,
  input logic         reset,
  r2r_adc_conv_if.master io_bus
);

  localparam int unsigned CH_W  = ch_width(NUM_CH);
  localparam int unsigned BIT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] CodeMax  = '1;
  localparam logic [WIDTH-1:0] SarStart = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [BIT_W-1:0] BitMsb   = BIT_W'(WIDTH - 1);
  localparam logic [CH_W-1:0]  ChLast   = CH_W'(NUM_CH - 1);

  adc_state_e       r_state, w_state_d;
  logic             r_mode, w_mode_d;
  logic [WIDTH-1:0] r_code, w_code_d;
  logic [BIT_W-1:0] r_bit, w_bit_d;
  logic [CH_W-1:0]  r_ch, w_ch_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [CH_W-1:0]  r_data_ch, w_data_ch_d;
  logic             r_valid, w_valid_d;

  logic             w_timer_load;
  logic             w_timer_done;
  logic             w_done;
  logic             w_start;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_code_sar;
  logic [BIT_W-1:0] w_bit_lo;

  adc_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .reset (reset),
    .i_load(w_timer_load),
    .o_done(w_timer_done)
  );

  always_comb begin
    w_state_d    = r_state;
    w_mode_d     = r_mode;
    w_code_d     = r_code;
    w_bit_d      = r_bit;
    w_ch_d       = r_ch;
    w_data_d     = r_data;
    w_data_ch_d  = r_data_ch;
    w_valid_d    = 1'b0;
    w_timer_load = 1'b0;
    w_done       = 1'b0;
    w_start      = 1'b0;
    w_result     = '0;
    w_code_sar   = r_code;
    w_bit_lo     = r_bit - BIT_W'(1);

    unique case (r_state)
      StIdle: begin
        // Start is handled below, shared with back-to-back restarts.
      end
      StSettle: begin
        if (w_timer_done) begin
          w_state_d = StDecide;
        end
      end
      StDecide: begin
        if (r_mode == ADC_MODE_SAR) begin
          // Keep the trial bit only if the input is still above the DAC.
          if (!io_bus.comp_result) begin
            w_code_sar[r_bit] = 1'b0;
          end
          if (r_bit != '0) begin
            w_code_sar[w_bit_lo] = 1'b1;
            w_code_d     = w_code_sar;
            w_bit_d      = w_bit_lo;
            w_state_d    = StSettle;
            w_timer_load = 1'b1;
          end else begin
            w_done   = 1'b1;
            w_result = w_code_sar;
          end
        end else begin
          if (!io_bus.comp_result) begin
            // Comparator just fell: the previous code was the last one below the input.
            w_done   = 1'b1;
            w_result = (r_code == '0) ? '0 : r_code - WIDTH'(1);
          end else if (r_code == CodeMax) begin
            w_done   = 1'b1;
            w_result = CodeMax;
          end else begin
            w_code_d     = r_code + WIDTH'(1);
            w_state_d    = StSettle;
            w_timer_load = 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_code_d  = '0;
      end
    endcase

    if (w_done) begin
      w_valid_d   = 1'b1;
      w_data_d    = w_result;
      w_data_ch_d = r_ch;
      w_ch_d      = (r_ch == ChLast) ? '0 : r_ch + CH_W'(1);
      w_state_d   = StIdle;
      w_code_d    = '0;
    end

    w_start = io_bus.enable && ((r_state == StIdle) || w_done);
    if (w_start) begin
      w_mode_d     = io_bus.mode;
      w_code_d     = (io_bus.mode == ADC_MODE_SAR) ? SarStart : '0;
      w_bit_d      = BitMsb;
      w_state_d    = StSettle;
      w_timer_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_mode    <= ADC_MODE_RAMP;
      r_code    <= '0;
      r_bit     <= '0;
      r_ch      <= '0;
      r_data    <= '0;
      r_data_ch <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_mode    <= w_mode_d;
      r_code    <= w_code_d;
      r_bit     <= w_bit_d;
      r_ch      <= w_ch_d;
      r_data    <= w_data_d;
      r_data_ch <= w_data_ch_d;
      r_valid   <= w_valid_d;
    end
  end

  assign io_bus.dac_code   = r_code;
  assign io_bus.ch_sel     = r_ch;
  assign io_bus.data_valid = r_valid;
  assign io_bus.data_out   = r_data;
  assign io_bus.data_ch    = r_data_ch;
  assign io_bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_r2r_adc_conv.sv
// Bench for r2r_adc_conv: WIDTH=8, SETTLE_CYCLES=4, NUM_CH=2, comparator = vin[ch] > dac_code.
// Stimulus pushes expected (data, channel, strobe cycle) into a queue; a monitor pops on
// every data_valid and compares.
module tb_r2r_adc_conv;
  import adc_pkg::*;

  localparam int W    = 8;
  localparam int S    = 4;
  localparam int N    = 2;
  localparam int STEP = S + 1;

  typedef struct {
    int data;
    int ch;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0     = 0;
  int   exp_ch = 0;
  int   vin [N];
  int   sar_seq [8] = '{128, 64, 96, 112, 104, 100, 98, 99};
  logic prev_valid = 1'b0;
  exp_t q [$];

  r2r_adc_conv_if #(.WIDTH(W), .NUM_CH(N)) bus ();

  r2r_adc_conv #(
    .WIDTH        (W),
    .SETTLE_CYCLES(S),
    .NUM_CH       (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  assign bus.comp_result = (vin[bus.ch_sel] > int'(bus.dac_code));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: the conversion starts on the next rising edge.
  task automatic start_conv(input logic m);
    bus.enable = 1'b1;
    bus.mode   = m;
    t0 = cyc + 1;
  endtask

  task automatic push(input int data, input int offset);
    exp_t e;
    e.data = data;
    e.ch   = exp_ch;
    e.cyc  = t0 + offset;
    q.push_back(e);
    exp_ch = (exp_ch + 1) % N;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dac_code"}, bus.dac_code, 0);
    check({tag, "_ch_sel"}, bus.ch_sel, 0);
    check({tag, "_data_out"}, bus.data_out, 0);
    check({tag, "_data_ch"}, bus.data_ch, 0);
    check({tag, "_data_valid"}, bus.data_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_dac_code"}, bus.dac_code, 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: data %0d ch %0d at cycle %0d, required no strobe",
                 bus.data_out, bus.data_ch, cyc);
      end else begin
        e = q.pop_front();
        check("result_data", bus.data_out, e.data);
        check("result_ch", bus.data_ch, e.ch);
        check("result_cycle", cyc, e.cyc);
      end
      check("strobe_width", prev_valid, 0);
    end
    prev_valid = bus.data_valid;
  end

  initial begin
    bus.enable = 1'b0;
    bus.mode   = ADC_MODE_RAMP;
    vin        = '{0, 0};
    tick(3);
    check_reset_outputs("por");
    reset = 1'b0;
    tick(1);

    // Ramp, vin 100: 101 steps.
    vin = '{100, 100};
    start_conv(ADC_MODE_RAMP);
    push(99, 101 * STEP);
    tick(1);
    check("ramp_busy", bus.busy, 1);
    check("ramp_start_code", bus.dac_code, 0);
    bus.enable = 1'b0;
    drain();
    tick(1);
    check_idle("ramp_done");

    // SAR, vin 100 on ch 1, with code trajectory.
    start_conv(ADC_MODE_SAR);
    push(99, 8 * STEP);
    tick(1);
    bus.enable = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("sar_code", bus.dac_code, sar_seq[j]);
      tick(STEP);
    end
    drain();
    tick(1);
    check_idle("sar_done");

    // vin 0 boundary.
    vin = '{0, 0};
    start_conv(ADC_MODE_RAMP);
    push(0, 1 * STEP);
    tick(1);
    bus.enable = 1'b0;
    drain();
    start_conv(ADC_MODE_SAR);
    push(0, 8 * STEP);
    tick(1);
    bus.enable = 1'b0;
    drain();

    // Comparator always 1.
    vin = '{300, 300};
    start_conv(ADC_MODE_RAMP);
    push(255, 256 * STEP);
    tick(1);
    bus.enable = 1'b0;
    drain();
    start_conv(ADC_MODE_SAR);
    push(255, 8 * STEP);
    tick(1);
    bus.enable = 1'b0;
    drain();

    // Continuous SAR, alternating channels.
    vin = '{50, 200};
    start_conv(ADC_MODE_SAR);
    push(49, 8 * STEP);
    push(199, 16 * STEP);
    push(49, 24 * STEP);
    tick(46);
    check("alt_ch_sel_1", bus.ch_sel, 1);
    tick(40);
    check("alt_ch_sel_0", bus.ch_sel, 0);
    bus.enable = 1'b0;
    drain();
    tick(1);
    check("alt_ch_sel_next", bus.ch_sel, 1);

    // enable dropped and mode flipped mid-SAR: still SAR, reported, then idle.
    start_conv(ADC_MODE_SAR);
    push(199, 8 * STEP);
    tick(13);
    bus.enable = 1'b0;
    bus.mode   = ADC_MODE_RAMP;
    drain();
    tick(1);
    check_idle("drop_mid_sar");

    // Mode flipped mid-ramp with enable held: takes effect on the next conversion only.
    start_conv(ADC_MODE_RAMP);
    push(49, 51 * STEP);
    push(199, 51 * STEP + 8 * STEP);
    tick(101);
    bus.mode = ADC_MODE_SAR;
    tick(165);
    bus.enable = 1'b0;
    drain();
    tick(1);
    check_idle("mode_switch");

    // Reset mid-ramp: no strobe, outputs cleared, restart on channel 0.
    vin = '{100, 100};
    start_conv(ADC_MODE_RAMP);
    tick(31);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("mid_reset");
    exp_ch = 0;
    vin    = '{5, 5};
    reset  = 1'b0;
    t0     = cyc + 1;
    push(4, 6 * STEP);
    tick(1);
    bus.enable = 1'b0;
    check("restart_ch_sel", bus.ch_sel, 0);
    check("restart_busy", bus.busy, 1);
    drain();
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
